button_debouncer: RTL and testbench
===================================

# button_debouncer

Conditions raw push-button inputs on the iCE40HX8K-EVB board before they reach the Murax SoC. Each button is synchronised, debounced and converted to an active-high "pressed" level, one-cycle press/release pulses and a 4-bit press counter. Everything is packed into a 32-bit word that drives `io_gpioA_read`. The block sits between the board pins (BUT1/BUT2) and the SoC, in the `io_mainClk` domain after the PLL.

## Interface
- `BUTTON_COUNT`, default 2: number of buttons, 1..4.
- `DEBOUNCE_CYCLES`, default 240000: consecutive stable cycles required to accept a change (20 ms at 12 MHz). Legal range is ≥ 1. The counter width is clog2(DEBOUNCE_CYCLES+1).
- `ACTIVE_LOW`, default 1: raw pins read 0 when pressed.
- `io_mainClk` in 1: sole clock; all state is on its rising edge.
- `io_asyncReset` in 1: asynchronous, active-high reset.
- `io_buttons` in BUTTON_COUNT: raw, asynchronous button pins.
- `io_countClear` in 1: synchronous clear of all press counters.
- `io_pressed` out BUTTON_COUNT: debounced level, 1 = pressed.
- `io_pressPulse` out BUTTON_COUNT: one-cycle pulse on each accepted press.
- `io_releasePulse` out BUTTON_COUNT: one-cycle pulse on each accepted release.
- `io_gpioRead` out 32: packed status word for `io_gpioA_read`.

## Operation
- **Polarity:** `raw_i` = `io_buttons[i]` XOR `ACTIVE_LOW`, so 1 = pressed. This is applied before synchronisation.
- **Synchroniser:** each button has a 2-flop synchroniser; its output is `s_i`.
- **Per-button debounce state:** `stable_i`, `cnt_i`, `presses_i[3:0]`.
- **Debounce rule, evaluated each cycle:**
  - If `s_i == stable_i`: `cnt_i` ← 0.
  - Else if `cnt_i == DEBOUNCE_CYCLES-1`: `stable_i` ← `s_i` and `cnt_i` ← 0.
  - Else: `cnt_i` ← `cnt_i`+1.
- **Glitch rejection:** a glitch shorter than DEBOUNCE_CYCLES cycles resets the counter and never changes `stable_i`.
- **Pulses:** `io_pressPulse[i]` = 1 for exactly the cycle in which `stable_i` has just become 1 (registered alongside `stable_i`). `io_releasePulse[i]` behaves the same way for a transition to 0.
- **Press counter:** `presses_i` increments by 1 on each accepted press and wraps 15 → 0.
  - `io_countClear` = 1 sets every `presses_i` to 0.
  - If a clear and an accepted press occur in the same cycle, the result is 1 for that button.
- **`io_gpioRead` packing:**
  - Bits [3:0] = `io_pressed`, zero-extended above BUTTON_COUNT.
  - Bits [7:4] = 0.
  - Bits [8+4i+3 : 8+4i] = `presses_i` for i < BUTTON_COUNT.
  - Count slots for unused buttons are 0.
  - Bits [31:24] = 0.
- Buttons are fully independent; simultaneous events on different buttons are all honoured in the same cycle.

## Timing
- **Reset values:**
  - Synchroniser flops reset to the released level (post-polarity 0), so no spurious press appears after reset.
  - `stable_i` = 0, `cnt_i` = 0, `presses_i` = 0.
  - All outputs are 0: `io_pressed`, both pulse vectors and `io_gpioRead` = 32'h0000_0000.
- **Latency:** a raw change held steady is registered by the first sync flop at edge 1 and appears on `s_i` after edge 2. `stable_i`, `io_pressed` and the pulse then update at edge 2+DEBOUNCE_CYCLES. `io_gpioRead` updates on the same edge, because all its fields are registered state.
- **Rejection threshold:** a change that holds for only DEBOUNCE_CYCLES-1 cycles of `s_i` is rejected.
- **Pulse width and spacing:** each pulse is exactly 1 cycle wide. Press and release pulses of the same button are separated by at least DEBOUNCE_CYCLES cycles.
- **`io_countClear`:** takes effect on the next edge and is level-sensitive, so holding it keeps the counters at 0. Only a press accepted in a cycle where clear is asserted yields 1.
- **Reset during operation:** asserting `io_asyncReset` at any time immediately forces all state and outputs to their reset values, without waiting for a clock edge. After deassertion, a button that is physically held must be re-accepted through the full latency and produces a fresh press pulse.
- **Outputs:** all outputs are registered; there is no combinational path from input to output.

## Test plan
1. **Reset with button held.** `DEBOUNCE_CYCLES`=4, `ACTIVE_LOW`=1, `io_buttons`=2'b10 (button 0 held) during reset. Required: all outputs 0 during reset. After deassertion, `io_pressed[0]` rises and `io_pressPulse[0]` pulses once at edge 6, and `io_gpioRead` = 32'h0000_0101 afterwards.
2. **Glitch rejection.** `DEBOUNCE_CYCLES`=4. Drive button 1 low for 3 cycles, then high. Required: `io_pressed[1]` stays 0, no pulse, `io_gpioRead` stays 0. A 4-cycle low produces a press at edge 6 after the falling edge of the pin.
3. **Press/release and wrap.** 16 clean press/release sequences on button 1. Required: one press pulse and one release pulse per sequence, `presses_1` counts 1..15 and then wraps to 0, and `io_gpioRead[15:12]` tracks the count.
4. **Clear with simultaneous press.** Assert `io_countClear` in the exact cycle a press of button 0 is accepted, with `presses_0`=7 beforehand. Required: `presses_0` = 1, and `presses_1` = 0.
5. **Simultaneous independent buttons.** Release both buttons in the same cycle. Required: `io_releasePulse` = 2'b11 for one cycle and `io_pressed` = 2'b00 on the same edge.
6. **Asynchronous reset mid-debounce.** Assert `io_asyncReset` mid-debounce, between clock edges, while `cnt_0`=2. Required: outputs go to 0 immediately. After release with the pin still held, a fresh press is accepted after the full 2+DEBOUNCE_CYCLES latency.

Source files
------------

// File: rtl/button_debouncer.sv
// button_debouncer: synchronises, debounces and counts raw push-button presses,
// packing the status into a 32-bit word for the Murax GPIO read port.
module button_debouncer #(
  parameter int BUTTON_COUNT    = 2,
  parameter int DEBOUNCE_CYCLES = 240000,
  parameter bit ACTIVE_LOW      = 1'b1
) (
  input  logic                    io_mainClk,
  input  logic                    io_asyncReset,
  input  logic [BUTTON_COUNT-1:0] io_buttons,
  input  logic                    io_countClear,
  output logic [BUTTON_COUNT-1:0] io_pressed,
  output logic [BUTTON_COUNT-1:0] io_pressPulse,
  output logic [BUTTON_COUNT-1:0] io_releasePulse,
  output logic [31:0]             io_gpioRead
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);
  logic [3:0]  pressed4;
  logic [15:0] counts;
  for (genvar g = 0; g < 4; g++) begin : g_btn
    if (g < BUTTON_COUNT) begin : g_used
      logic meta_q, s_q, stable_q, stable_d, press_q, press_d, rel_q, rel_d, accept;
      logic [CW-1:0] cnt_q, cnt_d;
      logic [3:0] presses_q, presses_d;
      always_comb begin
        accept    = (s_q != stable_q) && (cnt_q == CNT_MAX);
        stable_d  = accept ? s_q : stable_q;
        cnt_d     = (s_q == stable_q || accept) ? '0 : cnt_q + CW'(1);
        press_d   = accept && s_q;
        rel_d     = accept && !s_q;
        // a clear coinciding with an accepted press leaves exactly that press counted
        presses_d = io_countClear ? {3'b0, press_d} : presses_q + {3'b0, press_d};
      end
      always_ff @(posedge io_mainClk or posedge io_asyncReset) begin
        if (io_asyncReset) begin
          meta_q    <= 1'b0;
          s_q       <= 1'b0;
          stable_q  <= 1'b0;
          cnt_q     <= '0;
          press_q   <= 1'b0;
          rel_q     <= 1'b0;
          presses_q <= '0;
        end else begin
          meta_q    <= io_buttons[g] ^ ACTIVE_LOW;
          s_q       <= meta_q;
          stable_q  <= stable_d;
          cnt_q     <= cnt_d;
          press_q   <= press_d;
          rel_q     <= rel_d;
          presses_q <= presses_d;
        end
      end
      assign io_pressed[g]      = stable_q;
      assign io_pressPulse[g]   = press_q;
      assign io_releasePulse[g] = rel_q;
      assign pressed4[g]        = stable_q;
      assign counts[4*g +: 4]   = presses_q;
    end else begin : g_unused
      assign pressed4[g]      = 1'b0;
      assign counts[4*g +: 4] = 4'h0;
    end
  end
  assign io_gpioRead = {8'h00, counts, 4'h0, pressed4};
endmodule

// File: tb/tb_button_debouncer.sv
// tb_button_debouncer: directed vector table plus hand sequences for the
// debouncer with DEBOUNCE_CYCLES=4, two active-low buttons.
module tb_button_debouncer;
  typedef struct {
    logic [1:0]  btn;
    logic        clr;
    int          n;
    logic [1:0]  pressed, press, rel;
    logic [31:0] gpio;
  } vec_t;
  logic        clk = 1'b0, rst = 1'b1, clr = 1'b0;
  logic [1:0]  btn = 2'b10, pressed, press, rel;
  logic [31:0] gpio;
  int          checks = 0, errors = 0;
  vec_t        tbl [11];
  button_debouncer #(.BUTTON_COUNT(2), .DEBOUNCE_CYCLES(4), .ACTIVE_LOW(1'b1)) dut (
    .io_mainClk(clk),
    .io_asyncReset(rst),
    .io_buttons(btn),
    .io_countClear(clr),
    .io_pressed(pressed),
    .io_pressPulse(press),
    .io_releasePulse(rel),
    .io_gpioRead(gpio)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk_zero(input string nm);
    chk({nm, " pressed"}, 32'(pressed), 32'h0);
    chk({nm, " press"}, 32'(press), 32'h0);
    chk({nm, " rel"}, 32'(rel), 32'h0);
    chk({nm, " gpio"}, gpio, 32'h0);
  endtask
  // change the pins, expect the pulses exactly at edge 6 and the new level from then on
  task automatic apply(input logic [1:0] b, input logic [1:0] p, input logic [1:0] r,
                       input logic [1:0] pr, input string nm);
    btn = b;
    for (int e = 1; e <= 7; e++) begin
      step();
      chk($sformatf("%s e%0d press", nm, e), 32'(press), e == 6 ? 32'(p) : 32'h0);
      chk($sformatf("%s e%0d rel", nm, e), 32'(rel), e == 6 ? 32'(r) : 32'h0);
      if (e >= 6) chk($sformatf("%s e%0d pressed", nm, e), 32'(pressed), 32'(pr));
    end
  endtask
  initial begin
    tbl[0]  = '{2'b10, 1'b0, 5, 2'b00, 2'b00, 2'b00, 32'h0000_0000};
    tbl[1]  = '{2'b10, 1'b0, 1, 2'b01, 2'b01, 2'b00, 32'h0000_0101};
    tbl[2]  = '{2'b10, 1'b0, 3, 2'b01, 2'b00, 2'b00, 32'h0000_0101};
    tbl[3]  = '{2'b00, 1'b0, 3, 2'b01, 2'b00, 2'b00, 32'h0000_0101};
    tbl[4]  = '{2'b10, 1'b0, 6, 2'b01, 2'b00, 2'b00, 32'h0000_0101};
    tbl[5]  = '{2'b00, 1'b0, 4, 2'b01, 2'b00, 2'b00, 32'h0000_0101};
    tbl[6]  = '{2'b10, 1'b0, 1, 2'b01, 2'b00, 2'b00, 32'h0000_0101};
    tbl[7]  = '{2'b10, 1'b0, 1, 2'b11, 2'b10, 2'b00, 32'h0000_1103};
    tbl[8]  = '{2'b10, 1'b0, 3, 2'b11, 2'b00, 2'b00, 32'h0000_1103};
    tbl[9]  = '{2'b10, 1'b0, 1, 2'b01, 2'b00, 2'b10, 32'h0000_1101};
    tbl[10] = '{2'b10, 1'b0, 2, 2'b01, 2'b00, 2'b00, 32'h0000_1101};
    #1;
    chk_zero("rst t0");
    for (int i = 0; i < 3; i++) begin
      step();
      chk_zero($sformatf("rst held %0d", i));
    end
    rst = 1'b0;
    for (int i = 0; i < 11; i++) begin
      btn = tbl[i].btn;
      clr = tbl[i].clr;
      for (int k = 0; k < tbl[i].n; k++) begin
        step();
        chk($sformatf("v%0d.%0d pressed", i, k), 32'(pressed), 32'(tbl[i].pressed));
        chk($sformatf("v%0d.%0d press", i, k), 32'(press), 32'(tbl[i].press));
        chk($sformatf("v%0d.%0d rel", i, k), 32'(rel), 32'(tbl[i].rel));
        chk($sformatf("v%0d.%0d gpio", i, k), gpio, tbl[i].gpio);
      end
    end
    clr = 1'b1;
    step();
    chk("clear 1", gpio, 32'h0000_0001);
    step();
    chk("clear held", gpio, 32'h0000_0001);
    clr = 1'b0;
    step();
    chk("clear off", gpio, 32'h0000_0001);
    for (int k = 1; k <= 16; k++) begin
      logic [31:0] kk;
      kk = 32'(k);
      apply(2'b00, 2'b10, 2'b00, 2'b11, $sformatf("wrap p%0d", k));
      chk($sformatf("wrap cnt%0d", k), 32'(gpio[15:12]), 32'(kk[3:0]));
      apply(2'b10, 2'b00, 2'b10, 2'b01, $sformatf("wrap r%0d", k));
    end
    chk("after wrap", gpio, 32'h0000_0001);
    for (int k = 0; k < 7; k++) begin
      apply(2'b11, 2'b00, 2'b01, 2'b00, $sformatf("b0 r%0d", k));
      apply(2'b10, 2'b01, 2'b00, 2'b01, $sformatf("b0 p%0d", k));
    end
    chk("b0 seven", gpio, 32'h0000_0701);
    apply(2'b11, 2'b00, 2'b01, 2'b00, "b0 rel");
    chk("b0 released", gpio, 32'h0000_0700);
    btn = 2'b10;
    for (int e = 1; e <= 5; e++) step();
    chk("clr+press pre", gpio, 32'h0000_0700);
    clr = 1'b1;
    step();
    chk("clr+press pulse", 32'(press), 32'h1);
    chk("clr+press gpio", gpio, 32'h0000_0101);
    clr = 1'b0;
    step();
    chk("clr+press after", gpio, 32'h0000_0101);
    apply(2'b00, 2'b10, 2'b00, 2'b11, "b1 press");
    chk("both pressed", gpio, 32'h0000_1103);
    apply(2'b11, 2'b00, 2'b11, 2'b00, "both rel");
    chk("both released", gpio, 32'h0000_1100);
    btn = 2'b10;
    for (int e = 1; e <= 4; e++) step();
    chk("pre async", gpio, 32'h0000_1100);
    #3;
    rst = 1'b1;
    #1;
    chk_zero("async rst");
    step();
    chk_zero("async rst edge");
    #2;
    rst = 1'b0;
    apply(2'b10, 2'b01, 2'b00, 2'b01, "post rst");
    chk("post rst gpio", gpio, 32'h0000_0101);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
